mc_datapath: RTL and testbench



---
 rtl/mc_pkg.sv | 25 ++
 rtl/mc_regfile.sv | 40 ++++
 rtl/mc_datapath.sv | 154 +++++++++++++++
 tb/tb_mc_datapath.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle datapath: ALU opcodes, sequencer states,
// and the hardwired-zero register index.
package mc_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  localparam int unsigned X0_IDX = 0;

endpackage

// File: rtl/mc_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// x0 reads as zero and ignores writes, plus a live tap of one register.
module mc_regfile
  import mc_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned A0_IDX     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [XLEN-1:0]       rd1,
  output logic [XLEN-1:0]       rd2,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [XLEN-1:0]       wd,
  output logic [XLEN-1:0]       a0
);

  localparam int unsigned NREG = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(X0_IDX);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (we && (wa != X0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == X0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == X0) ? '0 : regs[ra2];
  // Entry 0 is never written, so tapping it also yields zero.
  assign a0  = regs[ADDR_WIDTH'(A0_IDX)];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle datapath: accepts one decoded instruction, runs EXEC, optional
// MEM handshake and WB, then pulses done. Outputs are registered.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned A0_IDX     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  reg_write,
  input  logic                  write_src,
  input  logic                  alu_src,
  input  logic [2:0]            alu_ctrl,
  input  logic                  mem_write,
  input  logic [XLEN-1:0]       imm_op,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic                  mem_ack,
  output logic                  eq,
  output logic                  done,
  output logic [XLEN-1:0]       a0
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_t                state;
  logic [ADDR_WIDTH-1:0] q_rs1, q_rs2, q_rd;
  logic                  q_reg_write, q_write_src, q_alu_src, q_mem_write;
  alu_op_t               q_op;
  logic [XLEN-1:0]       q_imm;
  logic [XLEN-1:0]       alu_res, ld_data;

  logic [XLEN-1:0] op1, op2, rs2_val, alu_y, wb_data;
  logic [SHW-1:0]  shamt;
  logic            rf_we;

  mc_regfile #(
    .XLEN      (XLEN),
    .ADDR_WIDTH(ADDR_WIDTH),
    .A0_IDX    (A0_IDX)
  ) u_rf (
    .clk(clk),
    .rst(rst),
    .ra1(q_rs1),
    .ra2(q_rs2),
    .rd1(op1),
    .rd2(rs2_val),
    .we (rf_we),
    .wa (q_rd),
    .wd (wb_data),
    .a0 (a0)
  );

  assign op2   = q_alu_src ? q_imm : rs2_val;
  assign shamt = op2[SHW-1:0];

  always_comb begin
    alu_y = '0;
    case (q_op)
      ALU_ADD: alu_y = op1 + op2;
      ALU_SUB: alu_y = op1 - op2;
      ALU_AND: alu_y = op1 & op2;
      ALU_OR:  alu_y = op1 | op2;
      ALU_XOR: alu_y = op1 ^ op2;
      ALU_SLL: alu_y = op1 << shamt;
      ALU_SRL: alu_y = op1 >> shamt;
      ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
    endcase
  end

  // The write commits at the end of WB, ahead of the next EXEC read.
  assign rf_we   = (state == S_WB) && q_reg_write;
  assign wb_data = q_write_src ? ld_data : alu_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      issue_ready <= 1'b1;
      done        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      eq          <= 1'b0;
      alu_res     <= '0;
      ld_data     <= '0;
      q_rs1       <= '0;
      q_rs2       <= '0;
      q_rd        <= '0;
      q_reg_write <= 1'b0;
      q_write_src <= 1'b0;
      q_alu_src   <= 1'b0;
      q_mem_write <= 1'b0;
      q_op        <= ALU_ADD;
      q_imm       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue_valid) begin
            q_rs1       <= rs1;
            q_rs2       <= rs2;
            q_rd        <= rd;
            q_reg_write <= reg_write;
            q_write_src <= write_src;
            q_alu_src   <= alu_src;
            q_mem_write <= mem_write;
            q_op        <= alu_op_t'(alu_ctrl);
            q_imm       <= imm_op;
            issue_ready <= 1'b0;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_res   <= alu_y;
          eq        <= (op1 == op2);
          mem_addr  <= alu_y;
          mem_wdata <= rs2_val;
          mem_we    <= q_mem_write;
          if (q_write_src || q_mem_write) begin
            mem_req <= 1'b1;
            state   <= S_MEM;
          end else begin
            done  <= 1'b1;
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (!q_mem_write) ld_data <= mem_rdata;
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= S_WB;
          end
        end
        S_WB: begin
          done        <= 1'b0;
          issue_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: a transaction-level model of the register
// file and instruction timeline, checked every cycle, plus literal pins.
module tb_mc_datapath;
  import mc_pkg::*;

  logic        clk, rst, issue_valid;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write, write_src, alu_src, mem_write, mem_ack;
  logic [2:0]  alu_ctrl;
  logic [31:0] imm_op, mem_rdata;

  logic        issue_ready, mem_req, mem_we, eq, done;
  logic [31:0] mem_addr, mem_wdata, a0;
  logic        issue_ready16, mem_req16, mem_we16, eq16, done16;
  logic [15:0] mem_addr16, mem_wdata16, a016;

  mc_datapath dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .write_src(write_src),
    .alu_src(alu_src), .alu_ctrl(alu_ctrl), .mem_write(mem_write), .imm_op(imm_op),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .eq(eq), .done(done), .a0(a0)
  );

  mc_datapath #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready16),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .write_src(write_src),
    .alu_src(alu_src), .alu_ctrl(alu_ctrl), .mem_write(mem_write), .imm_op(imm_op[15:0]),
    .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(mem_addr16), .mem_wdata(mem_wdata16),
    .mem_rdata(mem_rdata[15:0]), .mem_ack(mem_ack), .eq(eq16), .done(done16), .a0(a016)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0, passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model state: architectural registers plus expected per-cycle outputs.
  logic [31:0] m_regs [32];
  logic        chk_en = 1'b0;
  logic        exp_ready, exp_done, exp_req, exp_we, exp_eq;
  logic [31:0] exp_addr, exp_wdata, exp_a0;
  int unsigned req_cnt;
  logic [31:0] last_addr, last_wdata;
  logic        last_we;

  function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("issue_ready", issue_ready, exp_ready);
      chk("done", done, exp_done);
      chk("mem_req", mem_req, exp_req);
      chk("eq", eq, exp_eq);
      chk("a0", a0, exp_a0);
      chk("issue_ready16", issue_ready16, exp_ready);
      chk("done16", done16, exp_done);
      chk("mem_req16", mem_req16, exp_req);
      if (exp_req) begin
        chk("mem_we", mem_we, exp_we);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("mem_we16", mem_we16, exp_we);
        chk("mem_addr16", mem_addr16, exp_addr & 32'hFFFF);
        chk("mem_wdata16", mem_wdata16, exp_wdata & 32'hFFFF);
      end
      if (mem_req) begin
        req_cnt++;
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
        last_we    = mem_we;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reset_exp();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    exp_ready = 1'b1; exp_done = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_eq = 1'b0; exp_addr = '0; exp_wdata = '0; exp_a0 = '0;
  endtask

  // Issues one instruction at an idle cycle and walks it to completion.
  task automatic run(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rdd, input logic asrc, input logic [31:0] imm,
                     input logic rw, input logic ws, input logic mw,
                     input int unsigned waitc, input logic [31:0] rdata);
    logic [31:0] a, b, res, wv;
    issue_valid = 1'b1; rs1 = r1; rs2 = r2; rd = rdd; alu_src = asrc; imm_op = imm;
    reg_write = rw; write_src = ws; mem_write = mw; alu_ctrl = op;
    a = m_regs[r1]; b = asrc ? imm : m_regs[r2]; wv = m_regs[r2];
    res = model_alu(op, a, b);
    tick();
    // Scramble the issue fields to show they were latched.
    issue_valid = 1'b0; rs1 = ~r1; rs2 = ~r2; rd = ~rdd; alu_src = ~asrc; imm_op = ~imm;
    reg_write = ~rw; write_src = ~ws; mem_write = ~mw; alu_ctrl = ~op;
    exp_ready = 1'b0;
    tick();
    exp_eq = (a == b); exp_addr = res; exp_wdata = wv; exp_we = mw;
    if (ws || mw) begin
      exp_req = 1'b1;
      req_cnt = 0;
      repeat (waitc) tick();
      mem_ack = 1'b1; mem_rdata = rdata;
      tick();
      mem_ack = 1'b0; mem_rdata = 32'h0BAD_F00D;
      exp_req = 1'b0;
    end
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0; exp_ready = 1'b1;
    if (rw && rdd != 5'd0) m_regs[rdd] = ws ? rdata : res;
    exp_a0 = m_regs[10];
  endtask

  task automatic addi(input logic [4:0] rdd, input logic [31:0] imm);
    run(ALU_ADD, 5'd0, 5'd0, rdd, 1'b1, imm, 1'b1, 1'b0, 1'b0, 0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; reg_write = 1'b0;
    write_src = 1'b0; alu_src = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
    alu_ctrl = '0; imm_op = '0; mem_rdata = '0; req_cnt = 0;
    tick();
    set_reset_exp();
    chk_en = 1'b1;
    chk("rst_mem_we", mem_we, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_a0_16", a016, 32'd0);
    rst = 1'b0;
    tick();

    addi(5'd10, 32'd5);
    chk("addi_a0", a0, 32'd5);

    addi(5'd1, 32'd7);
    addi(5'd2, 32'd7);
    run(ALU_SUB, 5'd1, 5'd2, 5'd10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    chk("sub_a0", a0, 32'd0);
    chk("sub_eq", eq, 32'd1);
    chk("sub_eq16", eq16, 32'd1);

    addi(5'd1, 32'hFFFF_FFFF);
    addi(5'd2, 32'd1);
    run(ALU_SLT, 5'd1, 5'd2, 5'd10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    chk("slt_a0", a0, 32'd1);
    chk("slt_eq", eq, 32'd0);

    addi(5'd3, 32'hF0F0_1234);
    run(ALU_AND, 5'd3, 5'd0, 5'd10, 1'b1, 32'h0FF0_FF00, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    run(ALU_OR,  5'd3, 5'd2, 5'd10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    run(ALU_XOR, 5'd3, 5'd1, 5'd10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    run(ALU_SLL, 5'd3, 5'd0, 5'd10, 1'b1, 32'h24, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    chk("sll_a0", a0, 32'h0F01_2340);
    run(ALU_SRL, 5'd3, 5'd0, 5'd10, 1'b1, 32'd8, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    chk("srl_a0", a0, 32'h00F0_F012);

    addi(5'd5, 32'h0F0);
    addi(5'd2, 32'h1234_5678);
    run(ALU_ADD, 5'd5, 5'd2, 5'd0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 3, 32'h0);
    chk("st_req_cycles", req_cnt, 32'd4);
    chk("st_addr", last_addr, 32'h100);
    chk("st_wdata", last_wdata, 32'h1234_5678);
    chk("st_we", last_we, 32'd1);

    run(ALU_ADD, 5'd5, 5'd0, 5'd10, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 3, 32'hDEAD_BEEF);
    chk("ld_a0", a0, 32'hDEAD_BEEF);
    chk("ld_we", last_we, 32'd0);

    addi(5'd0, 32'd9);
    chk("x0_a0_kept", a0, 32'hDEAD_BEEF);
    run(ALU_ADD, 5'd0, 5'd0, 5'd10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    chk("x0_reads_zero", a0, 32'd0);

    run(ALU_ADD, 5'd5, 5'd0, 5'd10, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 0, 32'h00C0_FFEE);
    chk("ld0_a0", a0, 32'h00C0_FFEE);

    addi(5'd10, 32'h1234);
    chk("a0_16_pre", a016, 32'h1234);
    addi(5'd1, 32'hFFFF_FFFF);
    run(ALU_ADD, 5'd1, 5'd0, 5'd10, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    chk("wrap32", a0, 32'd0);
    chk("wrap16", a016, 32'd0);

    // Reset in the middle of a store's memory wait.
    issue_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd2; rd = 5'd10; alu_src = 1'b1; imm_op = 32'h10;
    reg_write = 1'b1; write_src = 1'b0; mem_write = 1'b1; alu_ctrl = ALU_ADD;
    tick();
    issue_valid = 1'b0; exp_ready = 1'b0;
    tick();
    exp_req = 1'b1; exp_we = 1'b1; exp_addr = 32'h100; exp_wdata = m_regs[2];
    exp_eq = (m_regs[5] == 32'h10);
    rst = 1'b1;
    tick();
    set_reset_exp();
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFEED_FACE;
    tick();
    mem_ack = 1'b0;
    chk("rstmem_req", mem_req, 32'd0);
    chk("rstmem_ready", issue_ready, 32'd1);
    chk("rstmem_we", mem_we, 32'd0);
    chk("rstmem_addr", mem_addr, 32'd0);
    chk("rstmem_a0", a0, 32'd0);
    tick();
    run(ALU_ADD, 5'd5, 5'd2, 5'd10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    chk("rstmem_regs_zero", a0, 32'd0);
    chk("rstmem_regs_zero16", a016, 32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
